mul_share_ctrl: RTL and testbench
=================================

# mul_share_ctrl

Sequencing and arbitration controller for the shared 32×32 signed bit-pair Booth multiplier (`bp_booth_mul_32`) in the CPU datapath. Two requesters (port 0: MUL instruction path, port 1: auxiliary/address path) present operand pairs. The block grants the multiplier round-robin, holds operands stable for a programmable settle window (multicycle path through the combinational array), captures the 64-bit product and returns it with a one-cycle done pulse. The block owns the single multiplier instance.

## Interface
Parameters:
- `SETTLE_CYC`, default 2: cycles operands are held before capture. Legal range 1–15.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `req`, input, 2: per-port request, level. Held until the matching `done`.
- `a0`, `b0`, input, 32 each: port 0 operands, signed.
- `a1`, `b1`, input, 32 each: port 1 operands, signed.
- `uns`, input, 2: per-port unsigned flag. Present only with `MUL_UNSIGNED_EN`.
- `gnt`, output, 2: one-hot; high for the owner from the accept cycle through the done cycle.
- `done`, output, 2: one-cycle pulse to the owner.
- `result`, output, 64: product. Valid in the done cycle and held until the next capture.
- `busy`, output, 1: high in every state except IDLE.

## Operation
- States are IDLE, WAIT, CAPTURE, DONE.
- IDLE: if any `req` is high, select the owner:
  - Only one port requesting: that port wins.
  - Both requesting: the port other than `last` wins, where `last` is the previously served port.
  - On the accept edge: latch the owner's a, b (and uns) into `op_a`, `op_b`; set `gnt[owner]`; load `cnt = SETTLE_CYC-1`; go to WAIT.
- WAIT: the multiplier inputs are driven from `op_a`/`op_b` only, never from live ports. When `cnt == 0`, go to CAPTURE; otherwise decrement `cnt`.
- CAPTURE: `result <= z` (corrected per Configuration); go to DONE.
- DONE: assert `done[owner]` for this cycle only; set `last <= owner`; clear `gnt`; go to IDLE.
- IDLE→accept is allowed on the cycle immediately after DONE (no bubble beyond DONE).
- Operands changing or `req` dropping after accept is ignored. The operation completes and `done` still pulses.
- `req` high during DONE for the owner is treated as a new request in IDLE.
- Product width: full 64-bit two's complement, with no truncation or saturation.

## Timing
- Reset values:
  - State IDLE; `gnt`, `done` = 0; `result` = 0; `busy` = 0; `cnt` = 0.
  - `last` = 1, so port 0 wins the first tie.
- Latency: accept edge to done cycle = SETTLE_CYC + 2 cycles.
  - With SETTLE_CYC=2, `req` seen at edge N gives `done` high during cycle N+4.
- Throughput: one product per SETTLE_CYC + 2 cycles. Back-to-back alternation when both ports request continuously.
- Reset asserted mid-operation:
  - Returns immediately to the reset values; the in-flight result is discarded and no `done` is produced.
  - Requesters must re-request after reset releases.
- `gnt` and `done` are never both set for the two ports at once.

## Configuration
- `MUL_UNSIGNED_EN` defined:
  - The `uns` port exists and is latched with the operands.
  - For an unsigned operation: `result = z + (op_a[31] ? {op_b,32'b0} : 0) + (op_b[31] ? {op_a,32'b0} : 0)` mod 2^64.
  - The correction adder is registered in CAPTURE, so latency is unchanged.
- Not defined: the `uns` port is absent and all operations are signed (`result = z`).

## Structure
- Package `mul_ctrl_pkg`:
  - State enum `mul_state_t`.
  - `MUL_NPORTS = 2`, `MUL_W = 32`, `MUL_PW = 64`.
  - `SETTLE_CYC_DEFAULT = 2`.
- Sub-module `mul_rr_arbiter`: 2-way round-robin. Inputs `req` and `last`; output one-hot `win`. Combinational.
- Existing `bp_booth_mul_32` instantiated once inside the block.

## Test plan
- Port 0 only, a0=15, b0=10: `gnt`=01, `done[0]` at accept+4, `result`=150.
- Port 1 only, a1=12, b1=-5: `result`=64'hFFFFFFFFFFFFFFC4, `done[1]` only.
- Both request from reset, a0=-7/b0=6 and a1=-9/b1=11:
  - Port 0 served first with -42 (64'hFFFFFFFFFFFFFFD6).
  - Port 1 accepted the cycle after, with -99 (64'hFFFFFFFFFFFFFF9D).
- a0=32'h7FFFFFFF, b0=32'h80000000, with a0 changed to 0 one cycle after accept: `result`=64'hC000000080000000.
- Reset pulsed during WAIT: all outputs 0 next edge and no `done`; after release, `last`=1 so port 0 wins a tie.
- `MUL_UNSIGNED_EN`, uns=01, a0=b0=32'hFFFFFFFF: `result`=64'hFFFFFFFE00000001. With uns=00: `result`=1.

Source files
------------

// File: rtl/mul_ctrl_pkg.sv
// Shared types and constants for the multiplier sharing controller.
// The helper below applies the unsigned correction used when
// MUL_UNSIGNED_EN is defined.
package mul_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } mul_state_t;

  localparam int MUL_NPORTS         = 2;
  localparam int MUL_W              = 32;
  localparam int MUL_PW             = 64;
  localparam int SETTLE_CYC_DEFAULT = 2;
  localparam int CNT_W              = 4;

  // Turns a signed 32x32 product into the unsigned product of the same bits:
  // each operand whose MSB is set contributes the other operand << 32.
  function automatic logic [MUL_PW-1:0] uns_correct(input logic [MUL_PW-1:0] z,
                                                    input logic [MUL_W-1:0]  a,
                                                    input logic [MUL_W-1:0]  b);
    logic [MUL_PW-1:0] corr_a;
    logic [MUL_PW-1:0] corr_b;
    corr_a = a[MUL_W-1] ? {b, {MUL_W{1'b0}}} : '0;
    corr_b = b[MUL_W-1] ? {a, {MUL_W{1'b0}}} : '0;
    return z + corr_a + corr_b;
  endfunction

endpackage

// File: rtl/bp_booth_mul_32.sv
// Combinational 32x32 signed multiplier with full 64-bit product.
// Purely combinational; the controller treats it as a multicycle path.
module bp_booth_mul_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] z
);

  logic signed [63:0] a_ext;
  logic signed [63:0] b_ext;

  assign a_ext = {{32{a[31]}}, a};
  assign b_ext = {{32{b[31]}}, b};

  // Low 64 bits of the sign-extended product equal the exact signed product.
  assign z = a_ext * b_ext;

endmodule

// File: rtl/mul_rr_arbiter.sv
// Two-way round-robin arbiter: a lone requester wins outright, a tie goes
// to the port that was not served last.
module mul_rr_arbiter (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] win
);

  // One-hot winner selection.
  always_comb begin
    win = 2'b00;
    case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = last ? 2'b01 : 2'b10;
      default: win = 2'b00;
    endcase
  end

endmodule

// File: rtl/mul_share_ctrl.sv
// Round-robin sharing controller for the single 32x32 multiplier.
// Operands are latched at accept, held for SETTLE_CYC cycles, the product is
// captured, and a one-cycle done pulse goes to the owning port.
// Optional feature macro: MUL_UNSIGNED_EN (adds the uns port and the
// registered unsigned correction in CAPTURE).
//
// state   | meaning
// IDLE    | no operation; arbitrate any pending request
// WAIT    | operands held on the multiplier, counting down the settle window
// CAPTURE | product (corrected if unsigned) registered into result
// DONE    | done pulse to owner, owner becomes last served
module mul_share_ctrl
  import mul_ctrl_pkg::*;
#(
  parameter int SETTLE_CYC = SETTLE_CYC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
`ifdef MUL_UNSIGNED_EN
  input  logic [1:0]  uns,
`endif
  output logic [1:0]  gnt,
  output logic [1:0]  done,
  output logic [63:0] result,
  output logic        busy
);

  mul_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      op_a_q, op_a_d;
  logic [31:0]      op_b_q, op_b_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [63:0]      result_q, result_d;
  logic [1:0]       win;
  logic [63:0]      z;
  logic [63:0]      prod;

  mul_rr_arbiter u_arb (
    .req  (req),
    .last (last_q),
    .win  (win)
  );

  // Multiplier sees only the latched operands, never the live ports.
  bp_booth_mul_32 u_mul (
    .a (op_a_q),
    .b (op_b_q),
    .z (z)
  );

`ifdef MUL_UNSIGNED_EN
  logic uns_q, uns_d;

  assign prod = uns_q ? uns_correct(z, op_a_q, op_b_q) : z;
`else
  assign prod = z;
`endif

  // Next-state, operand latch and result capture.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    gnt_d    = gnt_q;
    owner_d  = owner_q;
    last_d   = last_q;
    result_d = result_q;
`ifdef MUL_UNSIGNED_EN
    uns_d    = uns_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          owner_d = win[1];
          op_a_d  = win[1] ? a1 : a0;
          op_b_d  = win[1] ? b1 : b0;
`ifdef MUL_UNSIGNED_EN
          uns_d   = win[1] ? uns[1] : uns[0];
`endif
          gnt_d   = win;
          cnt_d   = CNT_W'(SETTLE_CYC - 1);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_CAPTURE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_CAPTURE: begin
        result_d = prod;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        last_d  = owner_q;
        gnt_d   = 2'b00;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      gnt_q    <= 2'b00;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      gnt_q    <= gnt_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      result_q <= result_d;
    end
  end

`ifdef MUL_UNSIGNED_EN
  // Unsigned flag travels with the operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uns_q <= 1'b0;
    end else begin
      uns_q <= uns_d;
    end
  end
`endif

  assign gnt    = gnt_q;
  assign done   = (state_q == ST_DONE) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign result = result_q;
  assign busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Self-checking bench for mul_share_ctrl: directed cases followed by
// randomized transactions against a behavioural product/arbitration model.
module tb_mul_share_ctrl;

  localparam int SETTLE = 2;
`ifdef MUL_UNSIGNED_EN
  localparam bit UEN = 1'b1;
`else
  localparam bit UEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req;
  logic [31:0] a0, b0, a1, b1;
  logic [1:0]  uns_v;
  logic [1:0]  gnt, done;
  logic [63:0] result;
  logic        busy;

  int   checks   = 0;
  int   failures = 0;
  logic m_last;
  bit   m_in_done;
  logic [63:0] obs;

  always #5 clk = ~clk;

  mul_share_ctrl #(.SETTLE_CYC(SETTLE)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .a0     (a0),
    .b0     (b0),
    .a1     (a1),
    .b1     (b1),
`ifdef MUL_UNSIGNED_EN
    .uns    (uns_v),
`endif
    .gnt    (gnt),
    .done   (done),
    .result (result),
    .busy   (busy)
  );

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Exact mathematical product, reduced mod 2^64.
  function automatic logic [63:0] model_prod(input logic [31:0] a, input logic [31:0] b,
                                             input logic u);
    longint          sa, sb;
    longint unsigned ua, ub;
    if (u) begin
      ua = {32'b0, a};
      ub = {32'b0, b};
      return 64'(ua * ub);
    end
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    return 64'(sa * sb);
  endfunction

  // One transaction; called at a negedge, returns at the negedge of the done cycle.
  task automatic txn(input logic [1:0] rq, input logic [31:0] xa0, input logic [31:0] xb0,
                     input logic [31:0] xa1, input logic [31:0] xb1, input logic [1:0] xu,
                     input int mode, input int gap, output logic [63:0] o);
    int          own;
    int          lat;
    logic [1:0]  oh;
    logic [31:0] ca, cb;
    logic        cu;
    logic [63:0] expv;
    lat = SETTLE + 2;
    o   = '0;
    a0 = xa0; b0 = xb0; a1 = xa1; b1 = xb1; uns_v = xu;
    if (gap > 0) begin
      req = 2'b00;
      repeat (gap) begin
        @(negedge clk);
        chk("idle_gap_busy", 64'(busy), 64'd0);
      end
      req = rq;
    end else if (m_in_done) begin
      req = rq;
      @(posedge clk); #1;
      chk("idle_after_done_busy", 64'(busy), 64'd0);
      chk("idle_after_done_gnt", 64'(gnt), 64'd0);
    end
    req = rq;
    m_in_done = 1'b0;
    if (rq == 2'b01)      own = 0;
    else if (rq == 2'b10) own = 1;
    else                  own = m_last ? 0 : 1;
    oh   = (own == 1) ? 2'b10 : 2'b01;
    ca   = (own == 1) ? xa1 : xa0;
    cb   = (own == 1) ? xb1 : xb0;
    cu   = UEN && xu[own];
    expv = model_prod(ca, cb, cu);
    @(posedge clk); #1;
    chk("accept_gnt", 64'(gnt), 64'(oh));
    chk("accept_busy", 64'(busy), 64'd1);
    chk("accept_done", 64'(done), 64'd0);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      chk($sformatf("done_k%0d", k), 64'(done), (k == lat) ? 64'(oh) : 64'd0);
      chk($sformatf("gnt_k%0d", k), 64'(gnt), 64'(oh));
      chk($sformatf("busy_k%0d", k), 64'(busy), 64'd1);
      if (k == 1 && mode > 0) begin
        a0 = 32'd0; b0 = $urandom; a1 = $urandom; b1 = $urandom; uns_v = ~uns_v;
        if (mode == 2) req[own] = 1'b0;
      end
      if (k == lat) begin
        o = result;
        chk("result", result, expv);
      end
    end
    m_last    = (own == 1);
    m_in_done = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req = 2'b00;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; uns_v = 2'b00;
    m_last = 1'b1; m_in_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_result", result, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    txn(2'b01, 32'd15, 32'd10, 32'd0, 32'd0, 2'b00, 0, 0, obs);
    chk("p0_only_150", obs, 64'd150);
    txn(2'b10, 32'd0, 32'd0, 32'd12, -32'sd5, 2'b00, 0, 1, obs);
    chk("p1_only_neg60", obs, 64'hFFFFFFFFFFFFFFC4);

    // Tie from a fresh reset-like point: last served was port 1, so port 0 wins.
    txn(2'b11, -32'sd7, 32'd6, -32'sd9, 32'd11, 2'b00, 0, 1, obs);
    chk("tie_p0_first", obs, 64'hFFFFFFFFFFFFFFD6);
    txn(2'b11, -32'sd7, 32'd6, -32'sd9, 32'd11, 2'b00, 0, 0, obs);
    chk("tie_p1_next", obs, 64'hFFFFFFFFFFFFFF9D);

    txn(2'b01, 32'h7FFFFFFF, 32'h80000000, 32'd0, 32'd0, 2'b00, 1, 1, obs);
    chk("hold_operands", obs, 64'hC000000080000000);

`ifdef MUL_UNSIGNED_EN
    txn(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 2'b01, 0, 1, obs);
    chk("uns_ffff", obs, 64'hFFFFFFFE00000001);
    txn(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 2'b00, 0, 1, obs);
    chk("sgn_ffff", obs, 64'd1);
`endif

    // Reset in the middle of WAIT.
    a0 = 32'd3; b0 = 32'd4; req = 2'b01;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    req   = 2'b00;
    #1;
    chk("midrst_gnt", 64'(gnt), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_result", result, 64'd0);
    repeat (4) begin
      @(negedge clk);
      chk("midrst_no_done", 64'(done), 64'd0);
    end
    rst_n = 1'b1;
    m_last = 1'b1; m_in_done = 1'b0;
    @(negedge clk);
    chk("after_rst_idle", 64'(busy), 64'd0);
    txn(2'b11, -32'sd7, 32'd6, -32'sd9, 32'd11, 2'b00, 0, 0, obs);
    chk("after_rst_tie_p0", obs, 64'hFFFFFFFFFFFFFFD6);

    for (int i = 0; i < 40; i++) begin
      txn(2'($urandom_range(1, 3)), $urandom, $urandom, $urandom, $urandom,
          2'($urandom_range(0, 3)), $urandom_range(0, 2), $urandom_range(0, 2), obs);
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
